// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, drives the instruction memory address and fills the IF/ID register.
// Optional performance counters (fetch_cnt, stall_cnt) are built when IF_PERF_CNT_EN is defined.
module if_fetch_ctrl #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4),
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(48)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              id_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              busy,
  output logic              done
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] if_pc_q, if_pc_d;
  logic [31:0]       if_instr_q, if_instr_d;
  logic              if_valid_q, if_valid_d;
  logic              busy_q, done_q;
  logic              accept;
  logic [ADDR_W-1:0] br_target;

  // Branch targets are word aligned; the low two address bits are dropped.
  assign br_target = br_addr & ~ADDR_W'(3);
  assign accept    = (state_q == RUN) && !br_taken && (!if_valid_q || id_ready);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if_valid_d = if_valid_q;
    if (state_q == IDLE) begin
      if_valid_d = 1'b0;
      if (start) state_d = RUN;
    end else if (br_taken) begin
      pc_d       = br_target;
      if_valid_d = 1'b0;
      if_instr_d = '0;
      state_d    = (br_target <= LAST_ADDR) ? RUN : DONE;
    end else if (state_q == RUN) begin
      if (accept) begin
        if_instr_d = imem_instr;
        if_pc_d    = pc_q + PC_STEP;
        if_valid_d = 1'b1;
        pc_d       = pc_q + PC_STEP;
        if (pc_q == LAST_ADDR) state_d = DONE;
      end
    end else begin
      if (id_ready) if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= '0;
      if_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
      if_valid_q <= if_valid_d;
      busy_q     <= (state_d == RUN);
      done_q     <= (state_d == DONE);
    end
  end

  assign imem_addr = pc_q;
  assign if_valid  = if_valid_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign busy      = busy_q;
  assign done      = done_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  logic        stall_evt;

  // Stall cycles: a valid word is sitting in IF/ID that decode refuses.
  assign stall_evt = (state_q == RUN) && if_valid_q && !id_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (accept && (fetch_cnt_q != '1))    fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall_evt && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule
